// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg
// Shared types and defaults for the bit-serial subtractor slice.
//   state_e      : controller states (IDLE/SHIFT/DONE, encoded 00/01/10)
//   DEFAULT_N    : default operand width
//   DEFAULT_CW   : default counter width (2**CW must exceed N)
//   DEFAULT_LAST : index of the final shift for the default width
//   last_idx()   : index of the final shift for any width
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  localparam int DEFAULT_N  = 4;
  localparam int DEFAULT_CW = 3;

  function automatic int last_idx(input int n);
    return n - 1;
  endfunction

  localparam int DEFAULT_LAST = last_idx(DEFAULT_N);

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor
// One-bit combinational subtractor cell: a_i - b_i - bin_i.
// It is the borrow-form dual of the ripple adder's full-adder cell.
// Ports:
//   a_i    : minuend bit
//   b_i    : subtrahend bit
//   bin_i  : borrow in
//   d_o    : difference bit
//   bout_o : borrow out
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  // A borrow leaves the cell when b exceeds a outright, or when a and b
  // are equal and an incoming borrow has to be passed along.
  assign d_o    = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial N-bit subtractor computing diff = a - b - bin, LSB first,
// one bit per clock through a single full_subtractor cell and a
// registered borrow. Results are held until the next accepted start.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   start : request, only looked at in IDLE
//   a, b  : minuend / subtrahend, captured on the accepting edge
//   bin   : borrow-in, captured on the accepting edge
//   busy  : high while SHIFT or DONE
//   done  : one-cycle pulse, diff/bout valid
//   diff  : registered difference
//   bout  : registered final borrow-out
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int CW = DEFAULT_CW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout
);

  localparam logic [CW-1:0] LAST = CW'(last_idx(N));

  state_e        state_q;
  logic [N-1:0]  a_sr_q;
  logic [N-1:0]  b_sr_q;
  logic [N-1:0]  d_sr_q;
  logic [N-1:0]  d_sr_d;
  logic          borrow_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  diff_q;
  logic          bout_q;
  logic          busy_q;
  logic          done_q;
  logic          d_bit;
  logic          bo_bit;

  full_subtractor u_cell (
    .a_i    (a_sr_q[0]),
    .b_i    (b_sr_q[0]),
    .bin_i  (borrow_q),
    .d_o    (d_bit),
    .bout_o (bo_bit)
  );

  // New difference bits enter at the MSB so that after N shifts the first
  // (least significant) bit has arrived at position 0.
  assign d_sr_d = {d_bit, d_sr_q[N-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      d_sr_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sr_q   <= a;
            b_sr_q   <= b;
            borrow_q <= bin;
            cnt_q    <= '0;
            d_sr_q   <= '0;
            state_q  <= SHIFT;
            busy_q   <= 1'b1;
          end
        end
        SHIFT: begin
          d_sr_q   <= d_sr_d;
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          borrow_q <= bo_bit;
          cnt_q    <= cnt_q + CW'(1);
          // The final shift publishes the result directly from the
          // next-state value so diff is valid in the same cycle as done.
          if (cnt_q == LAST) begin
            diff_q  <= d_sr_d;
            bout_q  <= bo_bit;
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
// Directed vector table plus hand-written sequences for the serial
// subtractor with N=4: latency, back-to-back starts, ignored inputs while
// busy, asynchronous reset mid-operation and a full operand sweep.
module tb_serial_subtractor;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         bout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] expDiff;
    logic       expBout;
  } vec_t;

  vec_t vecs[9];

  serial_subtractor #(.N(4), .CW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something in the sequencing never returns
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one value and keep the running counts
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // Start one operation from IDLE and watch 12 cycles after acceptance,
  // recording when done fires, how long busy stays up and the final result
  task automatic applyStimulus(input logic [3:0] av, input logic [3:0] bv, input logic binv,
                               output logic [3:0] gotDiff, output logic gotBout,
                               output int doneAt, output int doneCnt, output int busyCnt);
    doneAt  = -1;
    doneCnt = 0;
    busyCnt = 0;
    @(negedge clk);
    a     = av;
    b     = bv;
    bin   = binv;
    start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0;
      end
      if (busy) busyCnt++;
      if (done) begin
        doneCnt++;
        if (doneAt < 0) doneAt = i;
      end
    end
    gotDiff = diff;
    gotBout = bout;
  endtask

  initial begin
    logic [3:0] gd;
    logic       gb;
    int         dAt;
    int         dCnt;
    int         bCnt;
    int         expD;
    int         expB;
    int         bad;
    int         doneIdx[$];

    vecs[0] = '{4'd9,  4'd5,  1'b0, 4'd4,  1'b0};
    vecs[1] = '{4'd5,  4'd9,  1'b0, 4'd12, 1'b1};
    vecs[2] = '{4'd0,  4'd0,  1'b1, 4'd15, 1'b1};
    vecs[3] = '{4'd15, 4'd15, 1'b0, 4'd0,  1'b0};
    vecs[4] = '{4'd7,  4'd2,  1'b0, 4'd5,  1'b0};
    vecs[5] = '{4'd0,  4'd1,  1'b0, 4'd15, 1'b1};
    vecs[6] = '{4'd8,  4'd0,  1'b1, 4'd7,  1'b0};
    vecs[7] = '{4'd3,  4'd3,  1'b1, 4'd15, 1'b1};
    vecs[8] = '{4'd12, 4'd3,  1'b0, 4'd9,  1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    #12;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_diff", diff, 0);
    checkOutput("reset_bout", bout, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: result, borrow, done position, busy length
    for (int v = 0; v < 9; v++) begin
      applyStimulus(vecs[v].a, vecs[v].b, vecs[v].bin, gd, gb, dAt, dCnt, bCnt);
      checkOutput($sformatf("vec%0d_diff", v), gd, vecs[v].expDiff);
      checkOutput($sformatf("vec%0d_bout", v), gb, vecs[v].expBout);
      checkOutput($sformatf("vec%0d_done_at", v), dAt, N + 1);
      checkOutput($sformatf("vec%0d_done_cnt", v), dCnt, 1);
      checkOutput($sformatf("vec%0d_busy_len", v), bCnt, N + 1);
    end

    // start held high: one acceptance every N+2 cycles, nothing in between
    @(negedge clk);
    a     = 4'd7;
    b     = 4'd2;
    bin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    bad = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        doneIdx.push_back(i);
        if (diff != 4'd5 || bout != 1'b0) bad++;
      end
    end
    start = 1'b0;
    checkOutput("hold_done_count", doneIdx.size(), 3);
    if (doneIdx.size() == 3) begin
      checkOutput("hold_first_done", doneIdx[0], N + 1);
      checkOutput("hold_gap1", doneIdx[1] - doneIdx[0], N + 2);
      checkOutput("hold_gap2", doneIdx[2] - doneIdx[1], N + 2);
    end
    checkOutput("hold_bad_results", bad, 0);
    repeat (8) @(negedge clk);

    // Inputs scrambled and start pulsed while busy: one clean operation
    @(negedge clk);
    a     = 4'd12;
    b     = 4'd3;
    bin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    dCnt = 0;
    bCnt = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done) dCnt++;
      if (busy) bCnt++;
      if (i <= N + 1) begin
        a     = 4'($urandom_range(0, 15));
        b     = 4'($urandom_range(0, 15));
        bin   = 1'($urandom_range(0, 1));
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    checkOutput("noise_done_cnt", dCnt, 1);
    checkOutput("noise_busy_len", bCnt, N + 1);
    checkOutput("noise_diff", diff, 9);
    checkOutput("noise_bout", bout, 0);

    // Asynchronous reset in the middle of the second SHIFT cycle
    @(negedge clk);
    a     = 4'd9;
    b     = 4'd5;
    bin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_busy", busy, 0);
    checkOutput("async_rst_done", done, 0);
    checkOutput("async_rst_diff", diff, 0);
    checkOutput("async_rst_bout", bout, 0);
    #1;
    rst_n = 1'b1;
    dCnt = 0;
    bad  = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dCnt++;
      if (diff != 4'd0 || busy) bad++;
    end
    checkOutput("post_rst_done", dCnt, 0);
    checkOutput("post_rst_idle", bad, 0);

    // Every operand combination against the modulo-16 reference
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          applyStimulus(4'(ai), 4'(bi), 1'(ci), gd, gb, dAt, dCnt, bCnt);
          expD = (ai - bi - ci) & 15;
          expB = (ai < bi + ci) ? 1 : 0;
          checkOutput($sformatf("sweep_%0d_%0d_%0d_diff", ai, bi, ci), gd, expD);
          checkOutput($sformatf("sweep_%0d_%0d_%0d_bout", ai, bi, ci), gb, expB);
          checkOutput($sformatf("sweep_%0d_%0d_%0d_done", ai, bi, ci), dCnt, 1);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor: computes diff = a - b - bin, LSB first, one bit per clock, through a single registered full-subtractor cell.
- Counterpart of the team's ripple-carry adder datapath. Used where area matters more than latency, and as a golden cross-check for the combinational adder in two's-complement tests.
- Start/done handshake toward the controlling logic. Results are held until the next accepted start.

Parameters:
- N, 4, operand and difference width in bits (N >= 2).
- CW, 3, counter width; must satisfy 2^CW > N.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  N  minuend; sampled on the accepting edge only.
- b  input  N  subtrahend; sampled on the accepting edge only.
- bin  input  1  borrow-in; sampled on the accepting edge only.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse; result valid.
- diff  output  N  difference, registered.
- bout  output  1  final borrow-out, registered.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, any time, including mid-operation): state=IDLE, busy=0, done=0, diff=0, bout=0. Internal a_sr, b_sr, d_sr, borrow and cnt are all cleared. Nothing resumes after reset releases.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1 at an edge: load a_sr=a, b_sr=b, borrow=bin, cnt=0, d_sr=0, go to SHIFT.
  - Otherwise stay in IDLE.
  - diff and bout are unchanged.
- SHIFT, on each edge:
  - d = a_sr[0] ^ b_sr[0] ^ borrow.
  - bo = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow).
  - d_sr = {d, d_sr[N-1:1]}, a_sr >>= 1, b_sr >>= 1, borrow = bo, cnt += 1.
  - On the edge where cnt == N-1 (the Nth shift): diff = {d, d_sr[N-1:1]}, bout = bo, go to DONE.
- DONE: done=1 for exactly this one cycle, then unconditionally go to IDLE.
- Latency and throughput:
  - Start is accepted at edge E0.
  - done is high in the cycle after edge EN.
  - Next acceptance is possible at E(N+2) at the earliest, so the minimum period is N+2 cycles.
- start is ignored while busy=1 (SHIFT or DONE). It is not queued.
- Changes on a, b or bin after the accepting edge have no effect on the operation in flight.
- Arithmetic:
  - diff = (a - b - bin) mod 2^N.
  - bout = 1 iff a < b + bin, unsigned; equivalently, the N+1-bit result is negative.
  - No overflow flag.
- diff and bout change only on the Nth SHIFT edge or on reset, and hold through IDLE.
- done and busy are registered, decoded from the state register, and glitch-free.
- Wrap-around: cnt is never compared beyond N-1. It is reset on every load.

Decomposition:
- Package serial_sub_pkg:
  - state enum {IDLE, SHIFT, DONE}, 2-bit encoding 00/01/10.
  - default N, CW.
  - helper constant LAST = N-1.
- Sub-module full_subtractor: purely combinational (a, b, bin -> d, bout), instantiated once in the datapath. It is the borrow-form dual of the existing adder cell.
- Everything else (FSM, shift registers, counter) stays in serial_subtractor.

Test Plan:
- Reset then a=9, b=5, bin=0, start one cycle -> busy=1 for 5 cycles; done pulses in the 5th cycle after accept; diff=4, bout=0.
- a=5, b=9, bin=0 -> diff=12 (4'b1100), bout=1. Then a=0, b=0, bin=1 -> diff=15, bout=1. Then a=15, b=15, bin=0 -> diff=0, bout=0.
- start held high continuously with a=7, b=2 -> accepted every 6 cycles; done pulses 6 cycles apart; diff=5 each time; no acceptance while busy.
- Accept a=12, b=3; change a/b/bin every cycle during SHIFT; pulse start during SHIFT and DONE -> diff=9, bout=0, a single done, no extra operation.
- Assert rst_n=0 asynchronously (mid-cycle) during the 2nd SHIFT cycle -> outputs immediately 0, state IDLE. After release with no start, done stays 0 and diff stays 0.
- Exhaustive sweep of all 512 (a, b, bin) combinations for N=4 -> diff/bout match the modulo-16 reference model; each done is exactly 1 cycle wide.
